// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: FSM state
// encodings, the hard-wired zero register index and default mult/div timing.
package mips_ctrl_pkg;

    // Hazard controller FSM states; the encoding is visible on the STATE port.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_e;

    // Register $zero is never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mult/div busy time and a counter width able to hold it.
    localparam int MD_LATENCY_DEF = 32;
    localparam int CNT_W_DEF      = 6;

endpackage : mips_ctrl_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Shared with the forwarding unit.
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_match_s;
    logic rt_match_s;

    // Compare the load destination against both ID sources; $zero never matches.
    always_comb begin
        rs_match_s = (ex_rt == id_rs);
        rt_match_s = id_uses_rt && (ex_rt == id_rt);
        if (ex_memread && (ex_rt != REG_ZERO)) begin
            load_use = rs_match_s || rt_match_s;
        end else begin
            load_use = 1'b0;
        end
    end

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Resolves branch
// flush, load-use / HI-LO stalls and I-memory misses in fixed priority, and
// tracks mult/div occupancy so HI/LO consumers wait for the result.
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_md_start,
    input  logic       id_hilo_read,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       imem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       md_busy,
    output logic       state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state_r;
    md_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    // Set on the first clock edge after reset is released; until then the
    // outputs keep their reset values even though reset has gone high.
    logic             run_en_r;

    logic             load_use_s;
    logic             md_hazard_s;
    logic             stall_s;
    logic             md_accept_s;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use_s)
    );

    assign md_busy = (state_r == ST_MD_WAIT);
    assign state   = logic'(state_r);

    // State, occupancy counter and reset-release flag; reset clears any
    // in-flight mult/div occupancy immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            cnt_r    <= CNT_ZERO;
            run_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            run_en_r <= 1'b1;
        end
    end

    // Hazard detection, priority output mux and FSM next-state logic.
    always_comb begin
        md_hazard_s = md_busy && (id_hilo_read || id_md_start);
        stall_s     = load_use_s || md_hazard_s;
        // A branch squashes the ID instruction; a stall holds it in ID.
        md_accept_s = reset && run_en_r && id_md_start && !ex_branch_taken && !stall_s;

        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset || !run_en_r) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end

        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (md_accept_s) begin
                    state_nxt_s = ST_MD_WAIT;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_MD_WAIT: begin
                // Counter runs regardless of branches, stalls or misses.
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_MD_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, checked against a remaining-busy-cycles reference model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_md_start;
    logic       id_hilo_read;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       imem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       md_busy;
    logic       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of mult/div occupancy left, and whether the
    // controller has seen a clock edge since reset was released.
    int m_remaining = 0;
    bit m_live      = 1'b0;

    pipeline_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_md_start     (id_md_start),
        .id_hilo_read    (id_hilo_read),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .state           (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit model_load_use();
        return ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    // Compare all outputs {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, state}.
    task automatic check_now(input string tag);
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        bit busy;
        bit hold;
        if (!reset) begin
            m_remaining = 0;
            m_live      = 1'b0;
        end
        busy = (m_remaining > 0);
        hold = model_load_use() || (busy && (id_hilo_read || id_md_start));
        if (!reset || !m_live)      exp_v[5:2] = 4'b0011;
        else if (ex_branch_taken)   exp_v[5:2] = 4'b1111;
        else if (hold)              exp_v[5:2] = 4'b0001;
        else if (!imem_ready)       exp_v[5:2] = 4'b0110;
        else                        exp_v[5:2] = 4'b1100;
        exp_v[1] = busy;
        exp_v[0] = busy;
        obs_v = {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, state};
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (pc,ifw,flush,bubble,busy,state)",
                   tag, obs_v, exp_v);
        end
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic end_cycle();
        bit accept;
        accept = m_live && reset && id_md_start && !ex_branch_taken &&
                 !model_load_use() && (m_remaining == 0);
        @(posedge clock);
        if (!reset) begin
            m_remaining = 0;
            m_live      = 1'b0;
        end else begin
            if (m_remaining > 0) m_remaining = m_remaining - 1;
            else if (accept)     m_remaining = LAT;
            m_live = 1'b1;
        end
        #1;
    endtask

    task automatic step(input string tag);
        #3;
        check_now(tag);
        end_cycle();
    endtask

    task automatic idle_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        id_md_start = 1'b0; id_hilo_read = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0;
        ex_branch_taken = 1'b0; imem_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        // Reset holds outputs regardless of inputs.
        step("reset_idle");
        ex_branch_taken = 1'b1; id_md_start = 1'b1;
        step("reset_branch");
        idle_inputs();
        reset = 1'b1;
        step("reset_release_hold");
        step("run_idle");

        // Load-use on rs: exactly one stall cycle, then the load moves on.
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        step("load_use_rs");
        ex_memread = 1'b0;
        step("load_use_clear");
        // Load-use on rt only when rt is a source.
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        step("load_use_rt");
        id_uses_rt = 1'b0;
        step("rt_not_source");
        // $zero never stalls.
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        step("load_use_zero");
        // Branch wins over a load-use match.
        ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
        step("branch_over_stall");
        idle_inputs();

        // Mult/div occupancy then held mfhi.
        id_md_start = 1'b1;
        step("md_issue");
        id_md_start = 1'b0; id_hilo_read = 1'b1;
        for (int i = 1; i <= LAT; i++) step($sformatf("mfhi_held_%0d", i));
        step("mfhi_released");
        idle_inputs();

        // I-memory miss for three cycles.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("imem_miss_%0d", i));
        imem_ready = 1'b1;
        step("imem_back");

        // Squashed issue.
        id_md_start = 1'b1; ex_branch_taken = 1'b1;
        step("squash_issue");
        idle_inputs();
        step("squash_after");

        // Reset in the second MD_WAIT cycle.
        id_md_start = 1'b1;
        step("md_issue2");
        id_md_start = 1'b0;
        step("md_wait1");
        #2;
        check_now("md_wait2_pre");
        reset = 1'b0;
        #1;
        check_now("async_reset");
        end_cycle();
        step("reset_held");
        reset = 1'b1;
        step("release_hold2");
        id_hilo_read = 1'b1;
        step("no_stale_busy");
        idle_inputs();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 49) != 0);
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_memread      = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            imem_ready      = ($urandom_range(0, 4) != 0);
            id_md_start     = ($urandom_range(0, 5) == 0);
            id_hilo_read    = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
